// File: rtl/exec_sequencer.sv
// exec_sequencer: fetches variable-length instructions from instruction memory,
// drives the Executor's one-hot command flags and argument bus, and steps or
// redirects the program counter when the Executor reports completion.
// Optional build macro: EXEC_SEQ_WDOG_EN adds an EXEC-state watchdog that
// faults the sequencer if READY_FL_ never arrives within WDOG_CYCLES_ cycles.
module exec_sequencer #(
  parameter int unsigned WORD_SIZE_ = 32,
  parameter int unsigned ADDR_SIZE_ = 32,
  parameter logic [ADDR_SIZE_-1:0] RESET_PC_ = '0
`ifdef EXEC_SEQ_WDOG_EN
  ,
  parameter int unsigned WDOG_CYCLES_ = 64
`endif
) (
  input  logic                    CLK_,
  input  logic                    RST_N_,
  input  logic                    START_,
  output logic                    IMEM_RD_,
  output logic [ADDR_SIZE_-1:0]   IMEM_ADDR_,
  input  logic                    IMEM_VALID_,
  input  logic [WORD_SIZE_-1:0]   IMEM_DATA_,
  output logic                    EXEC_FL_,
  output logic [5:0]              CMD_FL_,
  output logic [3*WORD_SIZE_-1:0] CMD_ARG_,
  input  logic                    READY_FL_,
  input  logic                    JMP_FL_,
  input  logic [ADDR_SIZE_-1:0]   NEW_EXEC_ADDR_OFF_,
  output logic                    BUSY_,
  output logic                    HALTED_,
  output logic                    FAULT_,
  output logic [ADDR_SIZE_-1:0]   PC_
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_OP,
    S_FETCH_ARG,
    S_EXEC,
    S_HALT,
    S_FAULT
  } state_t;

  localparam logic [2:0] OP_HALT    = 3'd0;
  localparam logic [2:0] OP_ILLEGAL = 3'd7;

  state_t                        state;
  logic [2:0]                    code;
  logic [1:0]                    nargs;
  logic [1:0]                    arg_idx;
  logic [2:0][WORD_SIZE_-1:0]    args;
  logic [ADDR_SIZE_-1:0]         next_pc;

  // Number of argument words that follow each opcode.
  function automatic logic [1:0] arg_count(input logic [2:0] c);
    case (c)
      3'd1:             arg_count = 2'd3;
      3'd2, 3'd3:       arg_count = 2'd1;
      3'd4, 3'd5, 3'd6: arg_count = 2'd2;
      default:          arg_count = 2'd0;
    endcase
  endfunction

  // Opcode to {MOV,ADD,CMP,JMP,JEQ,JGG} one-hot command flags.
  function automatic logic [5:0] cmd_onehot(input logic [2:0] c);
    case (c)
      3'd1:    cmd_onehot = 6'b100000;
      3'd2:    cmd_onehot = 6'b010000;
      3'd3:    cmd_onehot = 6'b001000;
      3'd4:    cmd_onehot = 6'b000100;
      3'd5:    cmd_onehot = 6'b000010;
      3'd6:    cmd_onehot = 6'b000001;
      default: cmd_onehot = 6'b000000;
    endcase
  endfunction

  assign CMD_ARG_ = args;

  // Program counter after the current instruction completes (mod 2^ADDR_SIZE_).
  assign next_pc = JMP_FL_ ? (PC_ + NEW_EXEC_ADDR_OFF_)
                           : (PC_ + ADDR_SIZE_'(1) + ADDR_SIZE_'(nargs));

`ifdef EXEC_SEQ_WDOG_EN
  localparam int unsigned WDW = $clog2(WDOG_CYCLES_ + 1);
  logic [WDW-1:0] wdog_cnt;
  logic           wdog_hit;

  // Limit is reached on the edge that would make the count WDOG_CYCLES_.
  assign wdog_hit = (wdog_cnt == WDW'(WDOG_CYCLES_ - 1));
`endif

  // Sequencer FSM with registered outputs; updates on the Executor's edge.
  always_ff @(negedge CLK_) begin
    if (!RST_N_) begin
      state      <= S_IDLE;
      PC_        <= RESET_PC_;
      IMEM_RD_   <= 1'b0;
      IMEM_ADDR_ <= RESET_PC_;
      EXEC_FL_   <= 1'b0;
      CMD_FL_    <= '0;
      args       <= '0;
      BUSY_      <= 1'b0;
      HALTED_    <= 1'b0;
      FAULT_     <= 1'b0;
      code       <= '0;
      nargs      <= '0;
      arg_idx    <= '0;
`ifdef EXEC_SEQ_WDOG_EN
      wdog_cnt   <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (START_) begin
            state      <= S_FETCH_OP;
            IMEM_RD_   <= 1'b1;
            IMEM_ADDR_ <= PC_;
            BUSY_      <= 1'b1;
          end
        end

        S_FETCH_OP: begin
          if (IMEM_VALID_) begin
            code    <= IMEM_DATA_[2:0];
            nargs   <= arg_count(IMEM_DATA_[2:0]);
            arg_idx <= '0;
            args    <= '0;
            if (IMEM_DATA_[2:0] == OP_HALT) begin
              state    <= S_HALT;
              IMEM_RD_ <= 1'b0;
              BUSY_    <= 1'b0;
              HALTED_  <= 1'b1;
            end else if (IMEM_DATA_[2:0] == OP_ILLEGAL) begin
              state    <= S_FAULT;
              IMEM_RD_ <= 1'b0;
              BUSY_    <= 1'b0;
              FAULT_   <= 1'b1;
            end else begin
              state      <= S_FETCH_ARG;
              IMEM_ADDR_ <= PC_ + ADDR_SIZE_'(1);
            end
          end
        end

        S_FETCH_ARG: begin
          if (IMEM_VALID_) begin
            args[arg_idx] <= IMEM_DATA_;
            if (arg_idx == nargs - 2'd1) begin
              state    <= S_EXEC;
              IMEM_RD_ <= 1'b0;
              CMD_FL_  <= cmd_onehot(code);
              EXEC_FL_ <= 1'b1;
`ifdef EXEC_SEQ_WDOG_EN
              wdog_cnt <= '0;
`endif
            end else begin
              arg_idx    <= arg_idx + 2'd1;
              IMEM_ADDR_ <= IMEM_ADDR_ + ADDR_SIZE_'(1);
            end
          end
        end

        S_EXEC: begin
          if (READY_FL_) begin
            state      <= S_FETCH_OP;
            EXEC_FL_   <= 1'b0;
            CMD_FL_    <= '0;
            PC_        <= next_pc;
            IMEM_ADDR_ <= next_pc;
            IMEM_RD_   <= 1'b1;
          end
`ifdef EXEC_SEQ_WDOG_EN
          else if (wdog_hit) begin
            state    <= S_FAULT;
            EXEC_FL_ <= 1'b0;
            CMD_FL_  <= '0;
            BUSY_    <= 1'b0;
            FAULT_   <= 1'b1;
          end else begin
            wdog_cnt <= wdog_cnt + WDW'(1);
          end
`endif
        end

        S_HALT: begin
          if (START_) begin
            state      <= S_FETCH_OP;
            PC_        <= PC_ + ADDR_SIZE_'(1);
            IMEM_ADDR_ <= PC_ + ADDR_SIZE_'(1);
            IMEM_RD_   <= 1'b1;
            HALTED_    <= 1'b0;
            BUSY_      <= 1'b1;
          end
        end

        S_FAULT: begin
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_sequencer.sv
// tb_exec_sequencer: scoreboard bench for exec_sequencer with a latency-
// configurable instruction memory model and a scripted Executor model.
module tb_exec_sequencer;

  logic        CLK_ = 1'b0;
  logic        RST_N_;
  logic        START_;
  logic        IMEM_RD_;
  logic [31:0] IMEM_ADDR_;
  logic        IMEM_VALID_;
  logic [31:0] IMEM_DATA_;
  logic        EXEC_FL_;
  logic [5:0]  CMD_FL_;
  logic [95:0] CMD_ARG_;
  logic        READY_FL_;
  logic        JMP_FL_;
  logic [31:0] NEW_EXEC_ADDR_OFF_;
  logic        BUSY_;
  logic        HALTED_;
  logic        FAULT_;
  logic [31:0] PC_;

  exec_sequencer dut (
    .CLK_(CLK_), .RST_N_(RST_N_), .START_(START_),
    .IMEM_RD_(IMEM_RD_), .IMEM_ADDR_(IMEM_ADDR_), .IMEM_VALID_(IMEM_VALID_),
    .IMEM_DATA_(IMEM_DATA_), .EXEC_FL_(EXEC_FL_), .CMD_FL_(CMD_FL_),
    .CMD_ARG_(CMD_ARG_), .READY_FL_(READY_FL_), .JMP_FL_(JMP_FL_),
    .NEW_EXEC_ADDR_OFF_(NEW_EXEC_ADDR_OFF_), .BUSY_(BUSY_), .HALTED_(HALTED_),
    .FAULT_(FAULT_), .PC_(PC_)
  );

  always #5 CLK_ = ~CLK_;

  typedef struct packed {
    logic [5:0]  fl;
    logic [95:0] arg;
    logic [31:0] pc;
    logic        jmp;
    logic [31:0] off;
    logic [7:0]  lat;
    logic        hang;
  } exec_entry_t;

  localparam logic [5:0] F_MOV = 6'b100000;
  localparam logic [5:0] F_ADD = 6'b010000;
  localparam logic [5:0] F_CMP = 6'b001000;
  localparam logic [5:0] F_JMP = 6'b000100;
  localparam logic [5:0] F_JEQ = 6'b000010;
  localparam logic [5:0] F_JGG = 6'b000001;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mem [0:63];
  int          mem_lat = 0;
  int          wait_cnt = 0;
  logic [31:0] held_addr;
  logic [31:0] fetch_q[$];
  exec_entry_t exec_q[$];
  exec_entry_t cur;
  bit          in_exec;
  int          lat_cnt;

  // Instruction memory model: answers after mem_lat idle cycles, checks address order and stability.
  initial begin
    logic [31:0] exp_addr;
    IMEM_VALID_ = 1'b0;
    IMEM_DATA_  = '0;
    forever begin
      @(posedge CLK_);
      IMEM_VALID_ = 1'b0;
      IMEM_DATA_  = 32'hBAD0_BAD0;
      if (IMEM_RD_ === 1'b1) begin
        if (wait_cnt != 0) begin
          n_cmp++;
          if (IMEM_ADDR_ !== held_addr) begin
            n_err++;
            $display("FAIL imem_addr_stable: got %h expected %h", IMEM_ADDR_, held_addr);
          end
        end
        held_addr = IMEM_ADDR_;
        if (wait_cnt >= mem_lat) begin
          IMEM_VALID_ = 1'b1;
          IMEM_DATA_  = mem[IMEM_ADDR_[5:0]];
          wait_cnt    = 0;
          n_cmp++;
          if (fetch_q.size() == 0) begin
            n_err++;
            $display("FAIL fetch_unexpected: got addr %h expected no fetch", IMEM_ADDR_);
          end else begin
            exp_addr = fetch_q.pop_front();
            if (IMEM_ADDR_ !== exp_addr) begin
              n_err++;
              $display("FAIL fetch_addr: got %h expected %h", IMEM_ADDR_, exp_addr);
            end
          end
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Executor model: checks each command on entry, answers READY_FL_ after the scripted latency.
  initial begin
    READY_FL_ = 1'b0;
    JMP_FL_ = 1'b0;
    NEW_EXEC_ADDR_OFF_ = '0;
    in_exec = 1'b0;
    lat_cnt = 0;
    cur = '0;
    forever begin
      @(posedge CLK_);
      READY_FL_ = 1'b0;
      JMP_FL_ = 1'b0;
      NEW_EXEC_ADDR_OFF_ = '0;
      if (EXEC_FL_ !== 1'b1) begin
        in_exec = 1'b0;
      end else begin
        if (!in_exec) begin
          in_exec = 1'b1;
          lat_cnt = 0;
          n_cmp++;
          if (exec_q.size() == 0) begin
            n_err++;
            $display("FAIL exec_unexpected: got fl=%b pc=%h expected no command", CMD_FL_, PC_);
            cur = '0;
            cur.hang = 1'b1;
          end else begin
            cur = exec_q.pop_front();
            if (CMD_FL_ !== cur.fl || CMD_ARG_ !== cur.arg || PC_ !== cur.pc) begin
              n_err++;
              $display("FAIL exec_cmd: got fl=%b arg=%h pc=%h expected fl=%b arg=%h pc=%h",
                       CMD_FL_, CMD_ARG_, PC_, cur.fl, cur.arg, cur.pc);
            end
          end
        end
        if (!cur.hang) begin
          if (lat_cnt == int'(cur.lat)) begin
            n_cmp++;
            if (CMD_FL_ !== cur.fl || CMD_ARG_ !== cur.arg) begin
              n_err++;
              $display("FAIL exec_hold: got fl=%b arg=%h expected fl=%b arg=%h",
                       CMD_FL_, CMD_ARG_, cur.fl, cur.arg);
            end
            READY_FL_ = 1'b1;
            JMP_FL_ = cur.jmp;
            NEW_EXEC_ADDR_OFF_ = cur.off;
          end
          lat_cnt++;
        end
      end
    end
  end

  // Hard stop if something wedges the whole run.
  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish expected finish before 300000");
    $fatal(1, "bench timeout");
  end

  task automatic push_fetch(input int lo, input int hi);
    for (int a = lo; a <= hi; a++) fetch_q.push_back(32'(a));
  endtask

  task automatic push_exec(input logic [5:0] fl, input logic [31:0] a0, input logic [31:0] a1,
                           input logic [31:0] a2, input logic [31:0] pc, input logic jmp,
                           input logic [31:0] off, input int lat, input logic hang);
    exec_entry_t e;
    e.fl = fl;
    e.arg = {a2, a1, a0};
    e.pc = pc;
    e.jmp = jmp;
    e.off = off;
    e.lat = 8'(lat);
    e.hang = hang;
    exec_q.push_back(e);
  endtask

  task automatic clear_mem;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
  endtask

  task automatic do_reset;
    @(posedge CLK_);
    RST_N_ = 1'b0;
    START_ = 1'b0;
    repeat (2) @(posedge CLK_);
    RST_N_ = 1'b1;
    clear_mem();
  endtask

  task automatic pulse_start;
    @(posedge CLK_);
    START_ = 1'b1;
    @(posedge CLK_);
    START_ = 1'b0;
  endtask

  // sel: 0 = HALTED_, 1 = FAULT_, 2 = EXEC_FL_; n = posedges waited.
  task automatic wait_flag(input int sel, input int max, output bit ok, output int n);
    ok = 1'b0;
    n = 0;
    while (!ok && n < max) begin
      @(posedge CLK_);
      n++;
      if ((sel == 0 && HALTED_ === 1'b1) || (sel == 1 && FAULT_ === 1'b1) ||
          (sel == 2 && EXEC_FL_ === 1'b1)) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    do_reset();
    n_cmp++;
    if ({IMEM_RD_, EXEC_FL_, BUSY_, HALTED_, FAULT_, CMD_FL_} !== 11'b0) begin
      n_err++;
      $display("FAIL reset_flags: got %b expected %b",
               {IMEM_RD_, EXEC_FL_, BUSY_, HALTED_, FAULT_, CMD_FL_}, 11'b0);
    end
    n_cmp++;
    if (PC_ !== 32'h0 || IMEM_ADDR_ !== 32'h0 || CMD_ARG_ !== 96'h0) begin
      n_err++;
      $display("FAIL reset_regs: got pc=%h addr=%h arg=%h expected all zero", PC_, IMEM_ADDR_, CMD_ARG_);
    end
  endtask

  task automatic test_mov;
    bit ok;
    int n;
    do_reset();
    mem[0] = 32'h1; mem[1] = 32'h100; mem[2] = 32'hA; mem[3] = 32'h5; mem[4] = 32'h0;
    mem_lat = 0;
    push_fetch(0, 4);
    push_exec(F_MOV, 32'h100, 32'hA, 32'h5, 32'h0, 1'b0, 32'h0, 2, 1'b0);
    pulse_start();
    wait_flag(2, 30, ok, n);
    n_cmp++;
    if (ok !== 1'b1 || n != 4) begin
      n_err++;
      $display("FAIL mov_latency: got ok=%0d cycles=%0d expected ok=1 cycles=4", ok, n);
    end
    wait_flag(0, 50, ok, n);
    n_cmp++;
    if (ok !== 1'b1 || PC_ !== 32'd4 || IMEM_RD_ !== 1'b0 || BUSY_ !== 1'b0) begin
      n_err++;
      $display("FAIL mov_halt: got ok=%0d pc=%h rd=%b busy=%b expected ok=1 pc=4 rd=0 busy=0",
               ok, PC_, IMEM_RD_, BUSY_);
    end
    n_cmp++;
    if (fetch_q.size() != 0 || exec_q.size() != 0) begin
      n_err++;
      $display("FAIL mov_leftover: got fetch=%0d exec=%0d expected 0 0", fetch_q.size(), exec_q.size());
    end
  endtask

  task automatic test_slow_mem;
    bit ok;
    int n;
    do_reset();
    mem[0] = 32'h1; mem[1] = 32'h11; mem[2] = 32'h22; mem[3] = 32'h33;
    mem[4] = 32'hABCD_0002; mem[5] = 32'h44; mem[6] = 32'h0000_0008;
    mem_lat = 3;
    push_fetch(0, 6);
    push_exec(F_MOV, 32'h11, 32'h22, 32'h33, 32'h0, 1'b0, 32'h0, 1, 1'b0);
    push_exec(F_ADD, 32'h44, 32'h0, 32'h0, 32'h4, 1'b0, 32'h0, 0, 1'b0);
    pulse_start();
    wait_flag(0, 200, ok, n);
    mem_lat = 0;
    n_cmp++;
    if (ok !== 1'b1 || PC_ !== 32'd6) begin
      n_err++;
      $display("FAIL slow_halt: got ok=%0d pc=%h expected ok=1 pc=6", ok, PC_);
    end
    n_cmp++;
    if (fetch_q.size() != 0 || exec_q.size() != 0) begin
      n_err++;
      $display("FAIL slow_leftover: got fetch=%0d exec=%0d expected 0 0", fetch_q.size(), exec_q.size());
    end
  endtask

  task automatic test_jump;
    bit ok;
    int n;
    do_reset();
    mem[0] = 32'h4; mem[1] = 32'h1; mem[2] = 32'h2;
    mem[4] = 32'h4; mem[5] = 32'h5; mem[6] = 32'h6;
    mem[8] = 32'hFFFF_FF05; mem[9] = 32'h9; mem[10] = 32'hA;
    mem[11] = 32'h0;
    push_fetch(0, 2); push_fetch(8, 10); push_fetch(4, 6); push_fetch(8, 11);
    push_exec(F_JMP, 32'h1, 32'h2, 32'h0, 32'd0, 1'b1, 32'd8, 0, 1'b0);
    push_exec(F_JEQ, 32'h9, 32'hA, 32'h0, 32'd8, 1'b1, 32'hFFFF_FFFC, 1, 1'b0);
    push_exec(F_JMP, 32'h5, 32'h6, 32'h0, 32'd4, 1'b1, 32'd4, 0, 1'b0);
    push_exec(F_JEQ, 32'h9, 32'hA, 32'h0, 32'd8, 1'b0, 32'h0000_DEAD, 0, 1'b0);
    pulse_start();
    wait_flag(0, 100, ok, n);
    n_cmp++;
    if (ok !== 1'b1 || PC_ !== 32'd11) begin
      n_err++;
      $display("FAIL jump_halt: got ok=%0d pc=%h expected ok=1 pc=b", ok, PC_);
    end
    n_cmp++;
    if (fetch_q.size() != 0 || exec_q.size() != 0) begin
      n_err++;
      $display("FAIL jump_leftover: got fetch=%0d exec=%0d expected 0 0", fetch_q.size(), exec_q.size());
    end
  endtask

  task automatic test_halt_resume;
    bit ok;
    int n;
    do_reset();
    mem[0] = 32'h6; mem[1] = 32'h1; mem[2] = 32'h2;
    mem[20] = 32'h0; mem[21] = 32'h3; mem[22] = 32'h77; mem[23] = 32'h0;
    push_fetch(0, 2); push_fetch(20, 20);
    push_exec(F_JGG, 32'h1, 32'h2, 32'h0, 32'd0, 1'b1, 32'd20, 0, 1'b0);
    pulse_start();
    wait_flag(0, 50, ok, n);
    repeat (2) @(posedge CLK_);
    n_cmp++;
    if (ok !== 1'b1 || HALTED_ !== 1'b1 || IMEM_RD_ !== 1'b0 || PC_ !== 32'd20 || BUSY_ !== 1'b0) begin
      n_err++;
      $display("FAIL halt_state: got ok=%0d halted=%b rd=%b pc=%h busy=%b expected 1 1 0 14 0",
               ok, HALTED_, IMEM_RD_, PC_, BUSY_);
    end
    push_fetch(21, 23);
    push_exec(F_CMP, 32'h77, 32'h0, 32'h0, 32'd21, 1'b0, 32'h0, 0, 1'b0);
    pulse_start();
    wait_flag(0, 50, ok, n);
    n_cmp++;
    if (ok !== 1'b1 || PC_ !== 32'd23) begin
      n_err++;
      $display("FAIL resume_halt: got ok=%0d pc=%h expected ok=1 pc=17", ok, PC_);
    end
    n_cmp++;
    if (fetch_q.size() != 0 || exec_q.size() != 0) begin
      n_err++;
      $display("FAIL halt_leftover: got fetch=%0d exec=%0d expected 0 0", fetch_q.size(), exec_q.size());
    end
  endtask

  task automatic test_fault;
    bit ok;
    int n;
    do_reset();
    mem[0] = 32'h7;
    push_fetch(0, 0);
    pulse_start();
    wait_flag(1, 20, ok, n);
    n_cmp++;
    if (ok !== 1'b1 || IMEM_RD_ !== 1'b0 || BUSY_ !== 1'b0 || HALTED_ !== 1'b0) begin
      n_err++;
      $display("FAIL fault_entry: got ok=%0d rd=%b busy=%b halted=%b expected 1 0 0 0",
               ok, IMEM_RD_, BUSY_, HALTED_);
    end
    pulse_start();
    repeat (3) @(posedge CLK_);
    n_cmp++;
    if (FAULT_ !== 1'b1 || IMEM_RD_ !== 1'b0 || BUSY_ !== 1'b0) begin
      n_err++;
      $display("FAIL fault_sticky: got fault=%b rd=%b busy=%b expected 1 0 0", FAULT_, IMEM_RD_, BUSY_);
    end
    do_reset();
    n_cmp++;
    if ({IMEM_RD_, EXEC_FL_, BUSY_, HALTED_, FAULT_, CMD_FL_} !== 11'b0 || PC_ !== 32'h0) begin
      n_err++;
      $display("FAIL fault_reset: got flags=%b pc=%h expected flags=0 pc=0",
               {IMEM_RD_, EXEC_FL_, BUSY_, HALTED_, FAULT_, CMD_FL_}, PC_);
    end
  endtask

  task automatic test_reset_in_exec;
    bit ok;
    int n;
    do_reset();
    mem[0] = 32'h2; mem[1] = 32'h5A5A;
    push_fetch(0, 1);
    push_exec(F_ADD, 32'h5A5A, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 0, 1'b1);
    pulse_start();
    wait_flag(2, 20, ok, n);
    RST_N_ = 1'b0;
    @(posedge CLK_);
    n_cmp++;
    if (ok !== 1'b1 || EXEC_FL_ !== 1'b0 || CMD_FL_ !== 6'b0 || CMD_ARG_ !== 96'h0 ||
        BUSY_ !== 1'b0 || IMEM_RD_ !== 1'b0) begin
      n_err++;
      $display("FAIL exec_reset: got ok=%0d exec=%b fl=%b arg=%h busy=%b rd=%b expected 1 0 0 0 0 0",
               ok, EXEC_FL_, CMD_FL_, CMD_ARG_, BUSY_, IMEM_RD_);
    end
    RST_N_ = 1'b1;
  endtask

  task automatic test_watchdog;
    bit ok;
    int n;
    do_reset();
    mem[0] = 32'h3; mem[1] = 32'h33;
    push_fetch(0, 1);
    push_exec(F_CMP, 32'h33, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 0, 1'b1);
    pulse_start();
    wait_flag(2, 20, ok, n);
    n_cmp++;
    if (ok !== 1'b1) begin
      n_err++;
      $display("FAIL wdog_exec_entry: got %0d expected 1", ok);
    end
`ifdef EXEC_SEQ_WDOG_EN
    repeat (63) @(posedge CLK_);
    n_cmp++;
    if (FAULT_ !== 1'b0 || EXEC_FL_ !== 1'b1) begin
      n_err++;
      $display("FAIL wdog_early: got fault=%b exec=%b expected 0 1", FAULT_, EXEC_FL_);
    end
    @(posedge CLK_);
    n_cmp++;
    if (FAULT_ !== 1'b1 || EXEC_FL_ !== 1'b0 || CMD_FL_ !== 6'b0 || BUSY_ !== 1'b0) begin
      n_err++;
      $display("FAIL wdog_fire: got fault=%b exec=%b fl=%b busy=%b expected 1 0 0 0",
               FAULT_, EXEC_FL_, CMD_FL_, BUSY_);
    end
`else
    repeat (100) @(posedge CLK_);
    n_cmp++;
    if (EXEC_FL_ !== 1'b1 || FAULT_ !== 1'b0 || BUSY_ !== 1'b1 || CMD_FL_ !== F_CMP) begin
      n_err++;
      $display("FAIL exec_wait: got exec=%b fault=%b busy=%b fl=%b expected 1 0 1 %b",
               EXEC_FL_, FAULT_, BUSY_, CMD_FL_, F_CMP);
    end
`endif
    do_reset();
  endtask

  initial begin
    RST_N_ = 1'b0;
    START_ = 1'b0;
    clear_mem();
    test_reset();
    test_mov();
    test_slow_mem();
    test_jump();
    test_halt_resume();
    test_fault();
    test_reset_in_exec();
    test_watchdog();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/exec_sequencer.md
Name: exec_sequencer

Overview:
- Program sequencer that drives the Executor.
- Fetches variable-length instructions from an instruction memory through a request/valid port, decodes the opcode into the Executor's one-hot command flags and assembles the 3-word argument bus.
- Raises the execution flag and waits for the Executor's ready flag, then advances or redirects the program counter using the Executor's jump flag and offset.
- Sits between instruction memory and the Executor; the top level only starts it and watches its status.

Parameters:
- WORD_SIZE_, 32, instruction/argument word width.
- ADDR_SIZE_, 32, program counter / instruction memory address width.
- RESET_PC_, 0, program counter value after reset.
- WDOG_CYCLES_, 64, watchdog limit in cycles (used only with the optional feature).

Ports:
- CLK_  in  1  clock; all state updates on negedge CLK_, same edge as the Executor.
- RST_N_  in  1  synchronous, active-low reset, sampled on negedge CLK_.
- START_  in  1  start/resume request, sampled in IDLE and HALT only.
- IMEM_RD_  out  1  instruction word read request.
- IMEM_ADDR_  out  ADDR_SIZE_  word address of the request.
- IMEM_VALID_  in  1  IMEM_DATA_ valid for the current request.
- IMEM_DATA_  in  WORD_SIZE_  fetched word.
- EXEC_FL_  out  1  execute the command currently on CMD_FL_/CMD_ARG_.
- CMD_FL_  out  6  one-hot command flags: {MOV,ADD,CMP,JMP,JEQ,JGG} in bits 5..0.
- CMD_ARG_  out  3*WORD_SIZE_  argument words; word k in bits [32k+31:32k].
- READY_FL_  in  1  Executor finished the command.
- JMP_FL_  in  1  Executor takes the jump.
- NEW_EXEC_ADDR_OFF_  in  ADDR_SIZE_  jump offset from the Executor.
- BUSY_  out  1  high in FETCH_OP, FETCH_ARG and EXEC.
- HALTED_  out  1  high in HALT.
- FAULT_  out  1  high in FAULT (sticky).
- PC_  out  ADDR_SIZE_  address of the current instruction's opcode word.

Behaviour:
- Reset (RST_N_=0 at an edge, including mid-fetch or mid-EXEC):
  - state=IDLE, PC_=RESET_PC_.
  - EXEC_FL_, IMEM_RD_, BUSY_, HALTED_, FAULT_ = 0; CMD_FL_=0, CMD_ARG_=0, IMEM_ADDR_=RESET_PC_.
  - An in-flight IMEM_VALID_ is ignored.
- Opcode word format: bits [2:0] = code; all other bits ignored.
  - Codes: 0 HALT, 1 MOV, 2 ADD, 3 CMP, 4 JMP, 5 JEQ, 6 JGG, 7 illegal.
  - Argument words fetched: MOV 3, ADD 1, CMP 1, JMP/JEQ/JGG 2, HALT 0.
  - Unfetched CMD_ARG_ words are driven 0.
- IDLE:
  - START_=1 -> FETCH_OP with IMEM_RD_=1, IMEM_ADDR_=PC_.
- Fetch handshake:
  - IMEM_RD_ and IMEM_ADDR_ stay stable until an edge with IMEM_VALID_=1; IMEM_DATA_ is captured on that edge.
  - The next word's request starts on the same edge, so back-to-back valids give 1 word per cycle.
  - IMEM_VALID_ while IMEM_RD_=0 is ignored.
- FETCH_OP, on accept:
  - HALT -> HALT, IMEM_RD_=0.
  - Code 7 -> FAULT, IMEM_RD_=0.
  - Otherwise -> FETCH_ARG, IMEM_ADDR_=PC_+1.
- FETCH_ARG: word k (k=0..n-1) goes to CMD_ARG_ word k from address PC_+1+k.
  - On accepting the last word: IMEM_RD_=0, CMD_FL_ set to the decoded one-hot, EXEC_FL_=1, state=EXEC.
- EXEC:
  - CMD_FL_/CMD_ARG_/EXEC_FL_ are held until an edge with READY_FL_=1.
  - On that edge: EXEC_FL_=0, CMD_FL_=0, and JMP_FL_ is sampled.
    - JMP_FL_=1 -> PC_ = PC_ + NEW_EXEC_ADDR_OFF_.
    - JMP_FL_=0 -> PC_ = PC_ + 1 + n.
    - Then state=FETCH_OP with IMEM_RD_=1 at the new PC_.
  - PC_ arithmetic is mod 2^ADDR_SIZE_ (offset is two's-complement; wrap-around is legal).
- Minimum instruction latency: 1 + n fetch cycles + 1 EXEC cycle + Executor latency.
- HALT:
  - PC_ points at the HALT word.
  - START_=1 -> PC_=PC_+1, then FETCH_OP (resume).
- FAULT: sticky until reset; START_ is ignored.
- START_ in any other state is ignored.
- READY_FL_ outside EXEC is ignored.

Optional Feature:
- Macro: EXEC_SEQ_WDOG_EN.
- Defined:
  - A counter clears on EXEC entry and increments each cycle in EXEC.
  - If it reaches WDOG_CYCLES_ without READY_FL_: EXEC_FL_=0, CMD_FL_=0, state=FAULT, FAULT_=1.
  - READY_FL_ on the same edge as the limit wins (normal completion).
- Not defined: no counter; EXEC waits indefinitely.

Test Plan:
- Reset, START_=1; memory: [0]=MOV, [1..3]=0x00000100,0x0000000A,0x00000005; VALID every cycle -> CMD_FL_=6'b100000, CMD_ARG_={5,0xA,0x100}, EXEC_FL_=1 until READY_FL_; next fetch at address 4.
- IMEM_VALID_ delayed 3 cycles per word -> IMEM_ADDR_/IMEM_RD_ held stable, captured data correct, no word skipped.
- JEQ at PC 8 with JMP_FL_=1 and offset 0xFFFFFFFC -> next fetch at 4; with JMP_FL_=0 -> next fetch at 11.
- HALT at PC 20 -> HALTED_=1, IMEM_RD_=0, PC_=20; START_ -> fetch from 21.
- Opcode code 7 -> FAULT_=1 and stays 1 through START_; RST_N_=0 -> all outputs back to reset values, PC_=RESET_PC_.
- RST_N_=0 during EXEC -> EXEC_FL_=0 at that edge; with EXEC_SEQ_WDOG_EN and WDOG_CYCLES_=64 and READY_FL_ never asserted -> FAULT_=1 after 64 EXEC cycles.
